horner_eval: RTL and testbench

Sequential, parametrised polynomial evaluator using Horner's rule: p(x) = (((a_N·x + a_{N-1})·x + …)·x + a_0).
- Accepts one evaluation point and degree per job, then streams coefficients highest-order first over a valid/ready handshake.
- Delivers the W-bit result with a sticky overflow flag.
- Generalises the team's fixed two-term multiply-add datapath to arbitrary degree and width.
- Sits between a coefficient source (FIFO/ROM) and downstream arithmetic.

---
 rtl/horner_eval.sv | 105 ++++++++++
 tb/tb_horner_eval.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/horner_eval.sv
// horner_eval: sequential polynomial evaluator using Horner's rule.
//   p(x) = (((a_N*x + a_{N-1})*x + ...)*x + a_0), unsigned, modulo 2^W.
// A job is started in IDLE with an evaluation point and a degree N. The block
// then takes N+1 coefficients, highest order first, over a valid/ready
// handshake. It presents the W-bit result together with a sticky overflow
// flag until the result is accepted.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start, x, degree    job request, evaluation point, degree (sampled in IDLE)
//   coef_valid, coef    coefficient stream input
//   coef_ready          high in RUN
//   result_valid        high in DONE
//   result, overflow    accumulator and sticky overflow; hold outside DONE
//   result_ready        consumer accepts the result
//   busy                high in RUN and DONE
module horner_eval #(
    parameter int W     = 32,
    parameter int DEG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     x,
    input  logic [DEG_W-1:0] degree,
    input  logic             coef_valid,
    input  logic [W-1:0]     coef,
    output logic             coef_ready,
    output logic             result_valid,
    output logic [W-1:0]     result,
    output logic             overflow,
    input  logic             result_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     acc;
    logic [W-1:0]     x_reg;
    logic [DEG_W-1:0] count;
    logic             ovf;

    logic [2*W-1:0]   prod;
    logic [2*W:0]     full;
    logic             take;

    // Full-precision multiply-add. Any bit above W-1 means this step
    // wrapped, and that sets the sticky overflow flag.
    always_comb begin
        prod = {{W{1'b0}}, acc} * {{W{1'b0}}, x_reg};
        full = {1'b0, prod} + {{(W+1){1'b0}}, coef};
    end

    assign take = (state == RUN) && coef_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            x_reg <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg <= x;
                        count <= degree;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        acc <= full[W-1:0];
                        ovf <= ovf | (full[2*W:W] != '0);
                        // count holds the number of coefficients still to come
                        // after this one.
                        if (count == '0) state <= DONE;
                        else             count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded only from the state register, so
    // coef_ready never depends combinationally on coef_valid.
    assign coef_ready   = (state == RUN);
    assign result_valid = (state == DONE);
    assign busy         = (state == RUN) || (state == DONE);
    assign result       = acc;
    assign overflow     = ovf;

endmodule

// File: tb/tb_horner_eval.sv
module tb_horner_eval;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x;
    logic [3:0]  degree;
    logic        coef_valid;
    logic [31:0] coef;
    logic        coef_ready;
    logic        result_valid;
    logic [31:0] result;
    logic        overflow;
    logic        result_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    horner_eval #(.W(32), .DEG_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .degree(degree),
        .coef_valid(coef_valid), .coef(coef), .coef_ready(coef_ready),
        .result_valid(result_valid), .result(result), .overflow(overflow),
        .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // c[0] is streamed first (a_N). vpat bit k = coef_valid in RUN cycle k+1
    // (ones beyond bit 15). rr_hold = DONE cycles with result_ready low.
    typedef struct packed {
        logic [31:0]       x;
        logic [3:0]        deg;
        logic [15:0][31:0] c;
        logic [15:0]       vpat;
        logic [3:0]        rr_hold;
        logic              poke;
        logic [31:0]       exp_r;
        logic              exp_o;
        logic [7:0]        exp_lat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int idx, lat, hs, vc;
        logic [31:0] r0;
        @(negedge clk);
        start = 1'b1; x = v.x; degree = v.deg; coef_valid = 1'b0; result_ready = 1'b0;
        @(negedge clk);
        lat = 1; idx = 0; hs = 0; vc = 0;
        if (v.poke) x = 32'h0000_0099;   // start stays high: must be ignored
        else        start = 1'b0;
        chk("busy_run", 64'(busy), 64'd1);
        while (!result_valid && lat < 200) begin
            if (vc < 16 && !v.vpat[vc]) begin
                coef_valid = 1'b0; coef = 32'hDEAD_BEEF;
            end else begin
                coef_valid = 1'b1; coef = (idx < 16) ? v.c[idx] : 32'h0;
            end
            vc++;
            @(posedge clk);
            if (coef_valid && coef_ready) begin hs++; idx++; end
            @(negedge clk);
            lat++;
        end
        coef_valid = 1'b0;
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("result", 64'(result), 64'(v.exp_r));
        chk("overflow", 64'(overflow), 64'(v.exp_o));
        chk("handshakes", 64'(hs), 64'(v.deg) + 64'd1);
        r0 = result;
        for (int i = 0; i < int'(v.rr_hold); i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(result_valid), 64'd1);
            chk("hold_result", 64'(result), 64'(r0));
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0; start = 1'b0;
        chk("valid_drop", 64'(result_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("stay_idle", 64'(busy), 64'd0);
        chk("result_held", 64'(result), 64'(r0));
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            tbl[i] = '0;
            tbl[i].vpat = 16'hFFFF;
        end
        // basic
        tbl[0].x = 4; tbl[0].deg = 2; tbl[0].c[0] = 2; tbl[0].c[1] = 3; tbl[0].c[2] = 1;
        tbl[0].exp_r = 45; tbl[0].exp_lat = 4;
        // degree 0
        tbl[1].x = 7; tbl[1].c[0] = 32'h1234; tbl[1].exp_r = 32'h1234; tbl[1].exp_lat = 2;
        // product wrap: 2^32 -> 0
        tbl[2].x = 32'h0001_0000; tbl[2].deg = 2; tbl[2].c[0] = 1;
        tbl[2].exp_r = 0; tbl[2].exp_o = 1; tbl[2].exp_lat = 4;
        // flag cleared for next job
        tbl[3].x = 2; tbl[3].deg = 1; tbl[3].c[0] = 1; tbl[3].c[1] = 1;
        tbl[3].exp_r = 3; tbl[3].exp_lat = 3;
        // backpressure: valid 1,0,0,1,0,1 and 5 cycles of result_ready low
        tbl[4] = tbl[0]; tbl[4].vpat = 16'hFFE9; tbl[4].rr_hold = 5; tbl[4].exp_lat = 7;
        // start pulsed during RUN and DONE
        tbl[5] = tbl[0]; tbl[5].poke = 1'b1; tbl[5].rr_hold = 2;
        // sum-only carry: 0xFFFFFFFF*1 + 1
        tbl[6].x = 1; tbl[6].deg = 1; tbl[6].c[0] = 32'hFFFF_FFFF; tbl[6].c[1] = 1;
        tbl[6].exp_r = 0; tbl[6].exp_o = 1; tbl[6].exp_lat = 3;
        // maximum degree, x=1, all ones -> 16
        tbl[7].x = 1; tbl[7].deg = 15;
        for (int i = 0; i < 16; i++) tbl[7].c[i] = 1;
        tbl[7].exp_r = 16; tbl[7].exp_lat = 17;
        // job after mid-run reset: 2*3+5
        tbl[8].x = 3; tbl[8].deg = 1; tbl[8].c[0] = 2; tbl[8].c[1] = 5;
        tbl[8].exp_r = 11; tbl[8].exp_lat = 3;

        reset = 1'b1; start = 1'b0; x = '0; degree = '0; coef_valid = 1'b0;
        coef = '0; result_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_coef_ready", 64'(coef_ready), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Reset mid-run: degree 3, two coefficients accepted (acc = 1*5+2 = 7)
        @(negedge clk);
        start = 1'b1; x = 5; degree = 3;
        @(negedge clk);
        start = 1'b0; coef_valid = 1'b1; coef = 1;
        @(negedge clk);
        coef = 2;
        @(negedge clk);
        coef_valid = 1'b0;
        chk("mid_acc", 64'(result), 64'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_coef_ready", 64'(coef_ready), 64'd0);
        chk("mid_rst_result_valid", 64'(result_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        run_vec(tbl[8]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
